// File: rtl/sw_pkg.sv
// sw_pkg: shared state encoding, prescaler divide helper and synchroniser depth
// for the stopwatch controller.
package sw_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} sw_state_t;
    localparam int SYNC_DEPTH = 2;
    function automatic int calc_div(input int freq, input int tick_hz);
        return freq / tick_hz;
    endfunction
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: buttons, digit-chain handshake and status bundle between the
// controller (master) and its surroundings (slave).
interface stopwatch_ctrl_if #(parameter int N_DIGITS = 4);
    logic                btn_start_stop;
    logic                btn_lap_clear;
    logic [N_DIGITS-1:0] cnt_9;
    logic [N_DIGITS-1:0] digit_en;
    logic                digit_rst;
    logic                lap_hold;
    logic                running;
    logic [1:0]          state;
    modport master (
        input  btn_start_stop, btn_lap_clear, cnt_9,
        output digit_en, digit_rst, lap_hold, running, state
    );
    modport slave (
        output btn_start_stop, btn_lap_clear, cnt_9,
        input  digit_en, digit_rst, lap_hold, running, state
    );
endinterface

// File: rtl/sw_tick_gen.sv
// sw_tick_gen: base-tick prescaler; counts only while run, holds its phase when
// paused and returns to zero on clear.
module sw_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int W = DIV > 2 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt;
    if (DIV < 2) begin : g_bad_div
        $error("sw_tick_gen: DIV must be at least 2");
    end
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            cnt  <= cnt == LAST ? '0 : cnt + 1'b1;
            tick <= cnt == LAST;
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button sync/edge detect, start/pause/lap/clear FSM and BCD cascade.
// Optional macro SW_SATURATE_EN: hold at all-9s and pause instead of wrapping.
module stopwatch_ctrl
    import sw_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TICK_HZ     = 100,
    parameter int N_DIGITS    = 4
) (
    input  logic clk,
    input  logic reset,
    stopwatch_ctrl_if.master bus
);
    localparam int DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
        $error("stopwatch_ctrl: N_DIGITS must be 1..8");
    end
    logic [SYNC_DEPTH:0] ss_sync, lc_sync;
    logic ss_p, lc_p, tick, rst_r, sat, running, clr_req;
    logic [N_DIGITS-1:0] en;
    sw_state_t state, nxt;
    // Top bit of each shift register is the edge detector's previous sample
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync <= '0;
            lc_sync <= '0;
        end else begin
            ss_sync <= {ss_sync[SYNC_DEPTH-1:0], bus.btn_start_stop};
            lc_sync <= {lc_sync[SYNC_DEPTH-1:0], bus.btn_lap_clear};
        end
    end
    assign ss_p = ss_sync[SYNC_DEPTH-1] & ~ss_sync[SYNC_DEPTH];
    assign lc_p = lc_sync[SYNC_DEPTH-1] & ~lc_sync[SYNC_DEPTH];
`ifdef SW_SATURATE_EN
    assign sat = &bus.cnt_9;
`else
    assign sat = 1'b0;
`endif
    assign running = state == RUN || state == LAP;
    assign clr_req = lc_p & ~ss_p & (state == IDLE || state == PAUSE);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = ss_p ? RUN : IDLE;
            RUN:   nxt = ss_p || (sat && tick) ? PAUSE : lc_p ? LAP : RUN;
            LAP:   nxt = ss_p || (sat && tick) ? PAUSE : lc_p ? RUN : LAP;
            PAUSE: nxt = ss_p ? (sat ? PAUSE : RUN) : lc_p ? IDLE : PAUSE;
        endcase
    end
    // rst_r stretches digit_rst one cycle past reset and forms the clear pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rst_r <= 1'b1;
        end else begin
            state <= nxt;
            rst_r <= clr_req;
        end
    end
    sw_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .run   (running),
        .clear (state == IDLE),
        .tick  (tick)
    );
    assign en[0] = tick & running & ~bus.digit_rst & ~sat;
    for (genvar i = 1; i < N_DIGITS; i++) begin : g_cascade
        assign en[i] = en[i-1] & bus.cnt_9[i-1];
    end
    assign bus.digit_en  = en;
    assign bus.digit_rst = reset | rst_r;
    assign bus.lap_hold  = state == LAP;
    assign bus.running   = running;
    assign bus.state     = state;
endmodule
